rx_unstuff_shift: RTL and testbench
===================================

Name: rx_unstuff_shift

Overview:
- Receive-path stage directly downstream of the NRZI decoder.
- Consumes the decoded bit d_sent on each shift_enable strobe and removes USB stuffed bits (a forced 0 after STUFF_RUN consecutive 1s).
- Assembles de-stuffed bits LSB-first into DATA_W-bit words and presents each completed word with a one-cycle byte_ready pulse to the RX control unit and FIFO.
- Flags stuff violations.

Parameters:
- DATA_W, 8: width of the assembled word in bits.
- STUFF_RUN, 6: number of consecutive 1s after which the next bit is a stuffed bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- d_sent  input  1  decoded bit from the NRZI decoder; valid when shift_enable=1.
- shift_enable  input  1  one-cycle bit-sample strobe from the RX timer.
- eop  input  1  end-of-packet detected; qualified by shift_enable.
- rx_clear  input  1  one-cycle pulse from the RCU on sync detect; arms the block for a new packet.
- rx_data  output  DATA_W  last completed word, LSB = first received bit.
- byte_ready  output  1  one-cycle pulse; rx_data updated in the same cycle.
- stuff_err  output  1  one-cycle pulse on a stuff violation.

Behaviour:
- Reset: state=IDLE, shift register=0, bit count=0, ones run=0, rx_data=0, byte_ready=0, stuff_err=0. Reset mid-byte discards the partial word with no pulse.
- States:
  - IDLE: shift_enable is ignored. rx_clear -> SHIFT with bit count=0 and run=0.
  - SHIFT: on shift_enable & !eop, shift d_sent in: sr <= {d_sent, sr[DATA_W-1:1]}; bit count++.
    - d_sent=1: run++. d_sent=0: run=0.
    - If the run reaches STUFF_RUN on this bit -> STUFF.
    - When bit count reaches DATA_W: next edge rx_data <= assembled word, byte_ready=1 for one cycle, bit count=0. The run counter is NOT cleared at word boundaries, because stuffing spans bytes.
  - STUFF: on shift_enable & !eop:
    - d_sent=0: bit discarded (no shift, no count), run=0 -> SHIFT.
    - d_sent=1: stuff_err pulses next cycle, partial word discarded -> IDLE.
  - eop: shift_enable & eop in SHIFT or STUFF -> IDLE. The partial word is discarded with no byte_ready; counts are cleared.
- Priority in the same cycle: n_rst > rx_clear > eop > normal shift. rx_clear together with shift_enable re-arms and drops that bit.
- Latency: byte_ready asserts exactly one clk after the shift_enable cycle carrying the final bit.
- rx_data holds its value until the next completed word; it is never cleared except by reset.
- A word completing and a STUFF entry on the same bit are both legal: byte_ready pulses and the state becomes STUFF.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro RX_PARTIAL_FLAG_EN.
- Defined: adds output partial_err (1 bit, reset 0). It pulses one cycle when eop is accepted with bit count != 0, or while in STUFF with bit count != 0 (a misaligned packet end).
- Undefined: the port and its logic are absent, and eop discards the partial word silently.

Decomposition:
- Shared package usb_rx_pkg:
  - enum typedef rx_us_state_t {IDLE, SHIFT, STUFF}
  - constants STUFF_RUN_DEF=6, RX_WORD_W=8
- One natural sub-module, rx_ones_counter:
  - Saturating run counter of 1s with clear and increment inputs.
  - Outputs run_hit when the count equals STUFF_RUN.
- The shift register, bit counter and FSM stay in the top module.

Test Plan:
- Byte assembly: rx_clear, then bits 1,0,1,0,0,1,0,1 on 8 strobes -> one clk after the 8th strobe, byte_ready=1 and rx_data=0xA5; no stuff_err.
- Stuffing: after rx_clear, send 1,1,1,1,1,1,0(stuffed),1,1 -> byte_ready with rx_data=0xFF; the stuffed 0 is absent from the data.
- Stuff error: after rx_clear, send seven consecutive 1s -> stuff_err pulses one clk after the 7th strobe; state IDLE; no byte_ready; later strobes are ignored until rx_clear.
- Cross-byte stuffing: bytes 0xE0 then 0x1F -> the run of 6 ones spans the word boundary; 0 inserted after the 6th one is removed; outputs 0xE0, then 0x1F.
- Early EOP: 3 bits then shift_enable & eop -> no byte_ready; IDLE. With RX_PARTIAL_FLAG_EN, partial_err pulses once.
- Reset and clear: assert n_rst after 5 bits -> all outputs 0 immediately. rx_clear coincident with shift_enable -> that bit is dropped; the next 8 bits form a clean word.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive-path de-stuffing stage.
//   rx_us_state_t : de-stuff/shift FSM states
//   STUFF_RUN_DEF : default number of consecutive 1s before a stuffed 0
//   RX_WORD_W     : default assembled word width
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } rx_us_state_t;

  localparam int unsigned STUFF_RUN_DEF = 6;
  localparam int unsigned RX_WORD_W     = 8;

endpackage

// File: rtl/rx_ones_counter.sv
// Saturating counter of consecutive received 1s.
//   clk, n_rst : clock, asynchronous active-low reset
//   clr        : zero the run (received 0, packet abort, re-arm)
//   inc        : a 1 was accepted this cycle
//   run_hit    : the count after this cycle's update equals STUFF_RUN,
//                i.e. the bit being accepted now completes the run
module rx_ones_counter
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_RUN = STUFF_RUN_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic inc,
  output logic run_hit
);

  localparam int unsigned RW = $clog2(STUFF_RUN + 1);

  logic [RW-1:0] cnt_q;
  logic [RW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != RW'(STUFF_RUN))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Looks at the updated count so the FSM can enter STUFF on the same
  // strobe that carries the final 1 of the run.
  assign run_hit = (cnt_d == RW'(STUFF_RUN));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_unstuff_shift.sv
// USB receive bit de-stuffer and word assembler (downstream of NRZI decode).
//   clk, n_rst   : clock, asynchronous active-low reset
//   d_sent       : decoded bit, valid with shift_enable
//   shift_enable : one-cycle bit-sample strobe
//   eop          : end of packet, qualified by shift_enable
//   rx_clear     : re-arm for a new packet (sync detected)
//   rx_data      : last completed word, LSB = first received bit
//   byte_ready   : one-cycle pulse, rx_data updated in the same cycle
//   stuff_err    : one-cycle pulse on a stuff violation
//   partial_err  : only with RX_PARTIAL_FLAG_EN defined; one-cycle pulse when
//                  a packet ends with a partially assembled word
module rx_unstuff_shift
  import usb_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = RX_WORD_W,
  parameter int unsigned STUFF_RUN = STUFF_RUN_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_sent,
  input  logic              shift_enable,
  input  logic              eop,
  input  logic              rx_clear,
  output logic [DATA_W-1:0] rx_data,
  output logic              byte_ready,
`ifdef RX_PARTIAL_FLAG_EN
  output logic              partial_err,
`endif
  output logic              stuff_err
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_us_state_t      state_q, state_n;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_shifted;
  logic [CW-1:0]     cnt_q;
  logic              do_shift;
  logic              word_done;
  logic              eop_abort;
  logic              err_n;
  logic              cnt_clr;
  logic              run_inc;
  logic              run_clr;
  logic              run_hit;

  // Run control is kept outside the FSM process: the FSM consumes run_hit,
  // which is derived from these, so folding them in would form a loop.
  assign run_inc = !rx_clear && shift_enable && !eop && d_sent && (state_q == SHIFT);
  assign run_clr = rx_clear ||
                   (shift_enable && (state_q != IDLE) &&
                    (eop || !d_sent || (state_q == STUFF)));

  rx_ones_counter #(
    .STUFF_RUN(STUFF_RUN)
  ) u_ones (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (run_clr),
    .inc    (run_inc),
    .run_hit(run_hit)
  );

  always_comb begin
    state_n   = state_q;
    do_shift  = 1'b0;
    err_n     = 1'b0;
    eop_abort = 1'b0;
    if (rx_clear) begin
      state_n = SHIFT;
    end else if (shift_enable) begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (eop) begin
            eop_abort = 1'b1;
            state_n   = IDLE;
          end else begin
            do_shift = 1'b1;
            if (run_hit) state_n = STUFF;
          end
        end
        STUFF: begin
          if (eop) begin
            eop_abort = 1'b1;
            state_n   = IDLE;
          end else if (d_sent) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = SHIFT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign sr_shifted = {d_sent, sr_q[DATA_W-1:1]};
  assign word_done  = do_shift && (cnt_q == CW'(DATA_W - 1));
  assign cnt_clr    = rx_clear || eop_abort || err_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      rx_data    <= '0;
      byte_ready <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      state_q    <= state_n;
      byte_ready <= word_done;
      stuff_err  <= err_n;
      if (do_shift) sr_q <= sr_shifted;
      if (word_done) rx_data <= sr_shifted;
      if (cnt_clr || word_done) begin
        cnt_q <= '0;
      end else if (do_shift) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef RX_PARTIAL_FLAG_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      partial_err <= 1'b0;
    end else begin
      partial_err <= eop_abort && (cnt_q != '0);
    end
  end
`endif

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// Table-driven bench for rx_unstuff_shift. Each table row is one clock of
// inputs; its expected outputs are those visible just after that clock edge.
module tb_rx_unstuff_shift;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_sent;
  logic       shift_enable;
  logic       eop;
  logic       rx_clear;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       stuff_err;
`ifdef RX_PARTIAL_FLAG_EN
  logic       partial_err;
`endif

  always #5 clk = ~clk;

  rx_unstuff_shift #(
    .DATA_W   (8),
    .STUFF_RUN(6)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_sent      (d_sent),
    .shift_enable(shift_enable),
    .eop         (eop),
    .rx_clear    (rx_clear),
    .rx_data     (rx_data),
    .byte_ready  (byte_ready),
`ifdef RX_PARTIAL_FLAG_EN
    .partial_err (partial_err),
`endif
    .stuff_err   (stuff_err)
  );

  typedef struct {
    logic       clr;
    logic       se;
    logic       d;
    logic       eop;
    logic       br;
    logic [7:0] data;
    logic       err;
    logic       perr;
  } vec_t;

  vec_t        tbl[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic void v(input logic c, input logic s, input logic dd, input logic e,
                            input logic b, input logic [7:0] dt, input logic er,
                            input logic pe);
    vec_t r;
    r.clr = c; r.se = s; r.d = dd; r.eop = e;
    r.br = b; r.data = dt; r.err = er; r.perr = pe;
    tbl.push_back(r);
  endfunction

  // Plain data strobe row
  function automatic void bt(input logic dd, input logic b, input logic [7:0] dt);
    v(1'b0, 1'b1, dd, 1'b0, b, dt, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic b, input logic [7:0] dt,
                       input logic er, input logic pe);
    logic [10:0] got;
    logic [10:0] exp;
    got = {byte_ready, rx_data, stuff_err, 1'b0};
    exp = {b, dt, er, 1'b0};
`ifdef RX_PARTIAL_FLAG_EN
    got[0] = partial_err;
    exp[0] = pe;
`endif
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got br=%0b data=%h err=%0b p=%0b, expected br=%0b data=%h err=%0b p=%0b",
               name, got[10], got[9:2], got[1], got[0], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic dd, input logic e);
    rx_clear = c; shift_enable = s; d_sent = dd; eop = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    n_rst = 1'b0; d_sent = 1'b0; shift_enable = 1'b0; eop = 1'b0; rx_clear = 1'b0;
    #12;
    check("reset_state", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // A: 0xA5 assembly with an idle gap between strobes
    v(1,0,0,0, 0,8'h00,0,0);
    bt(1,0,8'h00); bt(0,0,8'h00); bt(1,0,8'h00);
    v(0,0,0,0, 0,8'h00,0,0);
    bt(0,0,8'h00); bt(0,0,8'h00); bt(1,0,8'h00); bt(0,0,8'h00);
    bt(1,1,8'hA5);
    v(0,0,0,0, 0,8'hA5,0,0);
    // B: six 1s, stuffed 0 removed, two more 1s -> 0xFF
    v(1,0,0,0, 0,8'hA5,0,0);
    for (int i = 0; i < 6; i++) bt(1,0,8'hA5);
    bt(0,0,8'hA5);
    bt(1,0,8'hA5); bt(1,1,8'hFF);
    v(0,0,0,0, 0,8'hFF,0,0);
    // C: seven 1s -> stuff_err, later strobes ignored
    v(1,0,0,0, 0,8'hFF,0,0);
    for (int i = 0; i < 6; i++) bt(1,0,8'hFF);
    v(0,1,1,0, 0,8'hFF,1,0);
    bt(1,0,8'hFF); bt(0,0,8'hFF);
    for (int i = 0; i < 8; i++) bt(1,0,8'hFF);
    // D: 0xE0 then 0x1F with the stuffed 0 across the word boundary
    v(1,0,0,0, 0,8'hFF,0,0);
    for (int i = 0; i < 5; i++) bt(0,0,8'hFF);
    bt(1,0,8'hFF); bt(1,0,8'hFF); bt(1,1,8'hE0);
    bt(1,0,8'hE0); bt(1,0,8'hE0); bt(1,0,8'hE0);
    bt(0,0,8'hE0);
    bt(1,0,8'hE0); bt(1,0,8'hE0); bt(0,0,8'hE0); bt(0,0,8'hE0);
    bt(0,1,8'h1F);
    // E: early EOP after 3 bits
    v(1,0,0,0, 0,8'h1F,0,0);
    bt(1,0,8'h1F); bt(0,0,8'h1F); bt(1,0,8'h1F);
    v(0,1,0,1, 0,8'h1F,0,1);
    for (int i = 0; i < 8; i++) bt(1,0,8'h1F);
    // F: word completes on the bit that enters STUFF (0xFC)
    v(1,0,0,0, 0,8'h1F,0,0);
    bt(0,0,8'h1F); bt(0,0,8'h1F);
    for (int i = 0; i < 5; i++) bt(1,0,8'h1F);
    bt(1,1,8'hFC);
    bt(0,0,8'hFC);
    bt(1,0,8'hFC);
    v(0,1,0,1, 0,8'hFC,0,1);
    // G: rx_clear with shift_enable drops that bit; next 8 bits -> 0x96
    bt(1,0,8'hFC);
    v(1,1,1,0, 0,8'hFC,0,0);
    bt(0,0,8'hFC); bt(1,0,8'hFC); bt(1,0,8'hFC); bt(0,0,8'hFC);
    bt(1,0,8'hFC); bt(0,0,8'hFC); bt(0,0,8'hFC);
    bt(1,1,8'h96);
    // H: rx_clear wins over eop in the same cycle
    v(1,1,0,1, 0,8'h96,0,0);
    for (int i = 0; i < 7; i++) bt(0,0,8'h96);
    bt(0,1,8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].se, tbl[i].d, tbl[i].eop);
      check($sformatf("vec%0d", i), tbl[i].br, tbl[i].data, tbl[i].err, tbl[i].perr);
    end
    step(0, 0, 0, 0);

    // Asynchronous reset while byte_ready is high
    step(1, 0, 0, 0);
    w = 8'h5A;
    for (int i = 0; i < 8; i++) step(0, 1, w[i], 0);
    check("pre_reset_word", 1'b1, 8'h5A, 1'b0, 1'b0);
    #1 n_rst = 1'b0;
    #1 check("async_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // Reset mid-byte discards the partial word
    step(1, 0, 0, 0);
    w = 8'h0D;
    for (int i = 0; i < 5; i++) step(0, 1, w[i], 0);
    #1 n_rst = 1'b0;
    #1 check("mid_byte_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 1'b1, 0);
    check("idle_after_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1, 0, 0, 0);
    w = 8'h3C;
    for (int i = 0; i < 7; i++) step(0, 1, w[i], 0);
    check("clean_word_pending", 1'b0, 8'h00, 1'b0, 1'b0);
    step(0, 1, w[7], 0);
    check("clean_word", 1'b1, 8'h3C, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    check("ready_one_cycle", 1'b0, 8'h3C, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
